// File: rtl/dff_pkg.sv
// Shared types and defaults for the D-type storage register.
// Optional inverted output is enabled with DFF_QN_EN.
package dff_pkg;

  localparam int DFF_WIDTH_DEFAULT = 1;

  typedef logic [DFF_WIDTH_DEFAULT-1:0] dff_data_t;

  localparam dff_data_t DFF_RESET_DEFAULT = '0;

endpackage

// File: rtl/dff_intf.sv
// Signal bundle between the register and its environment.
// Carries qn only when DFF_QN_EN is defined.
interface dff_intf
  import dff_pkg::*;
#(
  parameter int WIDTH = DFF_WIDTH_DEFAULT
);

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
`ifdef DFF_QN_EN
  logic [WIDTH-1:0] qn;
`endif

  modport DUT (
    input  clk,
    input  rst,
    input  d,
`ifdef DFF_QN_EN
    output qn,
`endif
    output q
  );

endinterface

// File: rtl/dff_bit.sv
// One-bit async-reset flop with its own reset value.
// Adds the registered complement output when DFF_QN_EN is defined.
module dff_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
`ifdef DFF_QN_EN
  output logic qn,
`endif
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= RST_VAL;
`ifdef DFF_QN_EN
      qn <= ~RST_VAL;
`endif
    end else begin
      q  <= d;
`ifdef DFF_QN_EN
      qn <= ~d;
`endif
    end
  end

endmodule

// File: rtl/dff_dut.sv
// WIDTH-bit positive-edge register built from per-bit flops.
// qn output present only when DFF_QN_EN is defined.
module dff_dut
  import dff_pkg::*;
#(
  parameter int               WIDTH       = DFF_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DFF_RESET_DEFAULT)
) (
  dff_intf.DUT vif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit #(
      .RST_VAL (RESET_VALUE[i])
    ) u_bit (
      .clk (vif.clk),
      .rst (vif.rst),
      .d   (vif.d[i]),
`ifdef DFF_QN_EN
      .qn  (vif.qn[i]),
`endif
      .q   (vif.q[i])
    );
  end

`ifndef SYNTHESIS
  a_rst_hold: assert property (
    @(posedge vif.clk) vif.rst |-> vif.q == RESET_VALUE
  );

  // Only check capture when no reset touched either edge.
  a_capture: assert property (
    @(posedge vif.clk)
      (!vif.rst && $past(!vif.rst)) |-> vif.q == $past(vif.d)
  );
`endif

endmodule

// File: tb/tb_dff_dut.sv
// Directed and random checks of dff_dut against a scoreboard.
// Also checks qn when built with DFF_QN_EN.
module tb_dff_dut;
  import dff_pkg::*;

  localparam int W = DFF_WIDTH_DEFAULT;
  localparam logic [W-1:0] RV = '0;

  logic clk;
  int checks;
  int errors;
  logic [W-1:0] sb[$];

  dff_intf #(.WIDTH(W)) vif ();

  dff_dut #(
    .WIDTH       (W),
    .RESET_VALUE (RV)
  ) u_dut (
    .vif (vif)
  );

  assign vif.clk = clk;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [W-1:0] exp);
    chk(tag, vif.q, exp);
`ifdef DFF_QN_EN
    chk({tag, "_qn"}, vif.qn, ~exp);
`endif
  endtask

  // Drive at negedge and record what the next edge must show.
  task automatic drive(input logic [W-1:0] dv, input logic rv);
    @(negedge clk);
    vif.d   = dv;
    vif.rst = rv;
    sb.push_back(rv ? RV : dv);
  endtask

  task automatic check_edge(input string tag);
    logic [W-1:0] exp;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      chk_q(tag, exp);
    end
  endtask

  initial begin
    logic [W-1:0] seq [5];
    logic [W-1:0] rd;
    logic         rr;
    checks = 0;
    errors = 0;
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    vif.rst = 1'b0;
    vif.d   = '0;
    #1;
    vif.rst = 1'b1;
    vif.d   = '1;
    #1;
    chk_q("rst_async", RV);

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_q("rst_hold_edge", RV);
      @(negedge clk);
      chk_q("rst_hold_mid", RV);
    end

    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b0);
      check_edge("capture");
    end

    drive('1, 1'b0);
    check_edge("pre_async");
    #4;
    vif.rst = 1'b1;
    #1;
    chk_q("async_mid", RV);
    @(negedge clk);
    chk_q("async_hold", RV);

    vif.d = '1;
    @(posedge clk);
    #0;
    vif.rst = 1'b0;
    #1;
    chk_q("release_edge", RV);
    sb.push_back(vif.d);
    check_edge("release_next");

    for (int i = 0; i < 20; i++) begin
      rd = W'($urandom);
      rr = ($urandom_range(0, 9) == 0);
      drive(rd, rr);
      check_edge("random");
    end

    drive('0, 1'b1);
    check_edge("final_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
